// File: rtl/regfile_mp.sv
// Multi-port register file: NUM_RD registered read ports, two write ports with write-first
// bypass, and a sequenced bulk-clear engine. Optional macro ZERO_REG_EN hardwires register 0 to zero.
module regfile_mp #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned DEPTH  = 32,
    parameter int unsigned NUM_RD = 2
) (
    input  logic                               CLK,
    input  logic                               RST,
    input  logic [NUM_RD*$clog2(DEPTH)-1:0]    RA,
    output logic [NUM_RD*WIDTH-1:0]            RD,
    input  logic                               WE0,
    input  logic [$clog2(DEPTH)-1:0]           WA0,
    input  logic [WIDTH-1:0]                   WD0,
    input  logic                               WE1,
    input  logic [$clog2(DEPTH)-1:0]           WA1,
    input  logic [WIDTH-1:0]                   WD1,
    input  logic                               CLR_REQ,
    output logic                               CLR_BUSY,
    output logic                               CLR_DONE
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DONE  = 2'd2
    } state_e;

    state_e                   state_q, state_d;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic [WIDTH-1:0]         mem_q [DEPTH];
    logic [WIDTH-1:0]         mem_d [DEPTH];
    logic [NUM_RD*WIDTH-1:0]  rd_q, rd_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic                     we0_ok, we1_ok;

`ifdef ZERO_REG_EN
    assign we0_ok = WE0 && (WA0 != '0);
    assign we1_ok = WE1 && (WA1 != '0);
`else
    assign we0_ok = WE0;
    assign we1_ok = WE1;
`endif

    // Clear sequencing and array update; host writes only land while idle
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mem_d   = mem_q;
        case (state_q)
            IDLE: begin
                if (CLR_REQ) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
                if (we0_ok) mem_d[WA0] = WD0;
                if (we1_ok) mem_d[WA1] = WD1;
            end
            CLEAR: begin
                mem_d[cnt_q[AW-1:0]] = '0;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(DEPTH - 1)) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
`ifdef ZERO_REG_EN
        mem_d[0] = '0;
`endif
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    // Read ports: port 1 bypass beats port 0, both beat the array; zeros while clearing
    always_comb begin : rd_mux
        logic [AW-1:0] ra;
        rd_d = '0;
        for (int unsigned k = 0; k < NUM_RD; k++) begin
            ra = RA[k*AW +: AW];
            if (state_q != IDLE)
                rd_d[k*WIDTH +: WIDTH] = '0;
            else if (we1_ok && (WA1 == ra))
                rd_d[k*WIDTH +: WIDTH] = WD1;
            else if (we0_ok && (WA0 == ra))
                rd_d[k*WIDTH +: WIDTH] = WD0;
            else
                rd_d[k*WIDTH +: WIDTH] = mem_q[ra];
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rd_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            mem_q   <= mem_d;
        end
    end

    assign RD       = rd_q;
    assign CLR_BUSY = busy_q;
    assign CLR_DONE = done_q;

endmodule
